// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU datapath: multiply/divide state encoding,
// operation codes and the documented multiply/divide latency.
package cpu_pkg;

  localparam int unsigned MD_WIDTH   = 32;
  localparam int unsigned MD_LATENCY = MD_WIDTH + 2;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StMulRun = 3'd2,
    StDivRun = 3'd3,
    StFinish = 3'd4
  } md_state_e;

endpackage

// File: rtl/md_step.sv
// One iteration of the multiply/divide unit: a radix-2 Booth step or a restoring-division
// step on the shared working register, selected by op.
module md_step
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             op,
  input  logic [WIDTH-1:0] opnd,
  input  logic [2*WIDTH:0] acc_in,
  output logic [2*WIDTH:0] acc_out
);

  logic [WIDTH:0]   upper;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem_new;
  logic [WIDTH-1:0] quo_new;
  logic             fits;

  always_comb begin
    // Booth add/sub is done one bit wider so adding -2^(W-1) cannot corrupt the shifted sign
    upper = {acc_in[2*WIDTH], acc_in[2*WIDTH:WIDTH+1]};
    sum   = upper;
    case (acc_in[1:0])
      2'b01:   sum = upper + {opnd[WIDTH-1], opnd};
      2'b10:   sum = upper - {opnd[WIDTH-1], opnd};
      default: sum = upper;
    endcase

    rem     = acc_in[2*WIDTH:WIDTH+1];
    quo     = acc_in[WIDTH:1];
    rem_sh  = {rem, quo[WIDTH-1]};
    fits    = rem_sh >= {1'b0, opnd};
    rem_new = fits ? WIDTH'(rem_sh - {1'b0, opnd}) : rem_sh[WIDTH-1:0];
    quo_new = {quo[WIDTH-2:0], fits};

    acc_out = (op == OP_DIV) ? {rem_new, quo_new, 1'b0} : {sum, acc_in[WIDTH:1]};
  end

endmodule

// File: rtl/mult_div_seq.sv
// Iterative signed multiply/divide unit feeding HI/LO. Booth radix-2 multiply and restoring
// division on magnitudes, one step per cycle; results hold until the next completion.
module mult_div_seq
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  md_state_e        state_q;
  logic             op_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] opnd_q;
  logic [2*WIDTH:0] acc_q;
  logic [2*WIDTH:0] step_out;
  logic [CntW-1:0]  cnt_q;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  // Magnitudes are unsigned W-bit, so |-2^(W-1)| is representable
  assign abs_a   = a_q[WIDTH-1] ? -a_q : a_q;
  assign abs_b   = b_q[WIDTH-1] ? -b_q : b_q;
  assign step_hi = step_out[2*WIDTH:WIDTH+1];
  assign step_lo = step_out[WIDTH:1];
  assign res_hi  = (op_q == OP_DIV && neg_rem_q) ? -step_hi : step_hi;
  assign res_lo  = (op_q == OP_DIV && neg_quo_q) ? -step_lo : step_lo;

  md_step #(
    .WIDTH(WIDTH)
  ) u_md_step (
    .op     (op_q),
    .opnd   (opnd_q),
    .acc_in (acc_q),
    .acc_out(step_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      op_q      <= OP_MULT;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            div_zero <= 1'b0;
            op_q     <= op;
            if (op == OP_DIV && b == '0) begin
              div_zero <= 1'b1;
              done     <= 1'b1;
              state_q  <= StFinish;
            end else begin
              a_q     <= a;
              b_q     <= b;
              busy    <= 1'b1;
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          cnt_q <= CntW'(WIDTH);
          if (op_q == OP_DIV) begin
            opnd_q    <= abs_b;
            acc_q     <= {{WIDTH{1'b0}}, abs_a, 1'b0};
            neg_quo_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
            neg_rem_q <= a_q[WIDTH-1];
            state_q   <= StDivRun;
          end else begin
            opnd_q  <= a_q;
            acc_q   <= {{WIDTH{1'b0}}, b_q, 1'b0};
            state_q <= StMulRun;
          end
        end
        StMulRun, StDivRun: begin
          acc_q <= step_out;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            hi      <= res_hi;
            lo      <= res_lo;
            state_q <= StFinish;
          end
        end
        StFinish: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: a latency/arithmetic model checked every cycle plus
// directed vectors with hand-computed results.
module tb_mult_div_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  mult_div_seq #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: returns {hi, lo} for a non-zero-divisor operation
  function automatic logic [63:0] model_op(input logic o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    longint p;
    int     sx, sy, q, r;
    if (!o) begin
      p = longint'($signed(x)) * longint'($signed(y));
      return p;
    end
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sx = x;
    sy = y;
    q  = sx / sy;
    r  = sx % sy;
    return {r, q};
  endfunction

  // Cycle-level model: accepted start -> done WIDTH+2 cycles later (1 cycle for div by zero)
  logic         m_busy, m_done, m_dz;
  logic [W-1:0] m_hi, m_lo;
  logic [63:0]  p_res;
  int           m_rem;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_rem  <= 0;
      p_res  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_hi   <= p_res[63:32];
          m_lo   <= p_res[31:0];
        end
      end else if (!m_done && start) begin
        if (op && b == '0) begin
          m_dz   <= 1'b1;
          m_done <= 1'b1;
        end else begin
          m_dz   <= 1'b0;
          m_busy <= 1'b1;
          m_rem  <= W + 1;
          p_res  <= model_op(op, a, b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("div_zero", 64'(div_zero), 64'(m_dz));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
    end
  end

  // Issue one operation and wait (bounded) for done; lat counts cycles from the start cycle
  task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    lat   = -1;
    bcnt  = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat, bcnt, ndone;

  initial begin
    #100_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);

    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, bcnt);
    chk("mul7x-3_lat", 64'(lat), 64'd34);
    chk("mul7x-3_busy_cycles", 64'(bcnt), 64'd33);
    chk("mul7x-3_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mul7x-3_lo", 64'(lo), 64'hFFFF_FFEB);

    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
    chk("mulmin_hi", 64'(hi), 64'h4000_0000);
    chk("mulmin_lo", 64'(lo), 64'h0);

    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    chk("div-7/2_lat", 64'(lat), 64'd34);
    chk("div-7/2_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div-7/2_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("div-7/2_dz", 64'(div_zero), 64'd0);

    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    chk("divovf_lo", 64'(lo), 64'h8000_0000);
    chk("divovf_hi", 64'(hi), 64'h0);
    chk("divovf_dz", 64'(div_zero), 64'd0);

    // 0x451 / 0x20 = 0x22 rem 0x11
    do_op(1'b1, 32'h451, 32'h20, lat, bcnt);
    chk("div_pre_hi", 64'(hi), 64'h11);
    chk("div_pre_lo", 64'(lo), 64'h22);

    do_op(1'b1, 32'd5, 32'd0, lat, bcnt);
    chk("div0_lat", 64'(lat), 64'd1);
    chk("div0_busy_cycles", 64'(bcnt), 64'd0);
    chk("div0_flag", 64'(div_zero), 64'd1);
    chk("div0_hi", 64'(hi), 64'h11);
    chk("div0_lo", 64'(lo), 64'h22);

    do_op(1'b0, 32'd6, 32'd9, lat, bcnt);
    chk("after_div0_dz", 64'(div_zero), 64'd0);
    chk("after_div0_lo", 64'(lo), 64'd54);

    // Restart attempt mid-run with changed operands must be ignored
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 32'd100;
    b     = 32'hFFFF_FFF7;
    ndone = 0;
    lat   = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 10) begin
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd5;
        b     = 32'd6;
      end
      if (k == 11) start = 1'b0;
      if (done) begin
        ndone++;
        lat = k;
      end
    end
    chk("midrun_ndone", 64'(ndone), 64'd1);
    chk("midrun_lat", 64'(lat), 64'd34);
    chk("midrun_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("midrun_lo", 64'(lo), 64'hFFFF_FC7C);

    // Asynchronous reset in the middle of a division
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_done", 64'(done), 64'd0);
    chk("async_rst_hi", 64'(hi), 64'd0);
    chk("async_rst_lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("post_rst_no_done", 64'(ndone), 64'd0);

    do_op(1'b0, 32'd3, 32'd4, lat, bcnt);
    chk("mul3x4_lat", 64'(lat), 64'd34);
    chk("mul3x4_lo", 64'(lo), 64'd12);
    chk("mul3x4_hi", 64'(hi), 64'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
